audio_sample_player: RTL and testbench
======================================

AUDIO_SAMPLE_PLAYER -- requirements
Module: audio_sample_player

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4535, clocks per sample period (100 MHz / 22.05 kHz); legal values CLK_DIV >= MEM_LATENCY+4.
REQ-002 SHALL have parameter ADDR_W, default 16, sample memory address width.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, cycles from mem_rd_en to valid mem_data.
REQ-004 SHALL have port clk, input, 1, 100 MHz clock.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle pulse; begin playback.
REQ-007 SHALL have port stop, input, 1, single-cycle pulse; abort playback.
REQ-008 SHALL have port loop_en, input, 1, restart at start_addr after end_addr.
REQ-009 SHALL have port start_addr, input, ADDR_W, first sample address.
REQ-010 SHALL have port end_addr, input, ADDR_W, last sample address, inclusive.
REQ-011 SHALL have port volume, input, 5, gain in 1/16 steps; values 17..31 treated as 16.
REQ-012 SHALL have port mem_addr, output, ADDR_W, sample memory read address.
REQ-013 SHALL have port mem_rd_en, output, 1, one-cycle memory read strobe.
REQ-014 SHALL have port mem_data, input, 8, unsigned offset-binary sample; midpoint 128.
REQ-015 SHALL have port music_data, output, 8, sample to the PWM stage; held between ticks.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at normal end of non-looping playback.

Function
REQ-018 SHALL implement states IDLE, FETCH, WAIT, HOLD.
REQ-019 In IDLE, start SHALL latch start_addr, end_addr and loop_en, set addr=start_addr, clear the tick counter and enter FETCH.
REQ-020 FETCH SHALL drive mem_addr=addr and mem_rd_en=1 for exactly one cycle, then enter WAIT.
REQ-021 WAIT SHALL count MEM_LATENCY cycles, capture mem_data into a sample buffer on the cycle data is valid, then enter HOLD.
REQ-022 The tick counter SHALL count 0..CLK_DIV-1 while busy and wrap; the tick fires on the cycle the count equals CLK_DIV-1.
REQ-023 The first tick SHALL occur CLK_DIV cycles after the edge that sampled start.
REQ-024 On a tick in HOLD, music_data SHALL update to scaled(buffer) on that same edge.
REQ-025 Scaling SHALL compute s=buffer-128 as 9-bit signed, multiply by the effective volume (0..16), arithmetic-shift right 4, then add 128; the result always fits 0..255 with no saturation.
REQ-026 Scaling SHALL use volume sampled at the tick edge.
REQ-027 On a tick with addr != end_addr, the block SHALL set addr=addr+1 modulo 2^ADDR_W and enter FETCH.
REQ-028 On a tick with addr == end_addr and loop_en latched 1, the block SHALL set addr=start_addr and enter FETCH.
REQ-029 On a tick with addr == end_addr and loop_en latched 0, the block SHALL pulse done and enter IDLE; music_data keeps the last sample until the next start or reset.
REQ-030 If start_addr > end_addr, addr SHALL wrap through 2^ADDR_W-1 to 0 until it equals end_addr.
REQ-031 stop SHALL force IDLE on the next edge from any state, set music_data=128, and not pulse done.
REQ-032 When start and stop are asserted in the same cycle, stop SHALL take priority.
REQ-033 start while busy SHALL restart per REQ-019 and SHALL NOT pulse done.
REQ-034 mem_rd_en SHALL never be high outside FETCH.

Reset
REQ-035 On reset the block SHALL enter IDLE and set music_data=128, busy=0, done=0, mem_rd_en=0, mem_addr=0, tick counter=0; reset overrides start and stop.

Verification (CLK_DIV=8, MEM_LATENCY=2)
REQ-036 Memory {0:200, 1:56, 2:128}, start_addr=0, end_addr=2, volume=16, loop_en=0, start pulse -> music_data is 200 at start+8, 56 at start+16, 128 at start+24; done pulses with the third tick; busy then falls.
REQ-037 Same setup with volume=8 -> outputs 164, 92, 128; with volume=0 -> all outputs 128; with volume=31 -> matches volume=16.
REQ-038 loop_en=1 -> the output sequence 200, 56, 128, 200, ... repeats every 24 cycles, done never pulses, and mem_addr wraps from 2 to 0.
REQ-039 start_addr=2^16-1, end_addr=0 -> reads occur at 65535 then 0, then done pulses.
REQ-040 stop applied mid-WAIT, and start+stop applied together -> IDLE next cycle, music_data=128, no done pulse, and no further mem_rd_en.
REQ-041 reset asserted in HOLD -> all outputs at the REQ-035 values on the next edge; a later start replays from start_addr.

Source files
------------

// File: rtl/audio_sample_player_if.sv
// Sample-memory read bus between the player (master) and the sample ROM/RAM (slave).
// Reads are strobed for one cycle; data returns a fixed number of cycles later.
interface audio_sample_player_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_data;

  modport master (output mem_addr, output mem_rd_en, input mem_data);
  modport slave  (input mem_addr, input mem_rd_en, output mem_data);
endinterface

// File: rtl/audio_sample_player.sv
// Plays offset-binary samples from memory at one sample per CLK_DIV clocks with volume scaling.
// First output CLK_DIV cycles after start; each sample is fetched and held before its tick.
module audio_sample_player #(
  parameter int CLK_DIV     = 4535,
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  input  logic [4:0]            volume,
  audio_sample_player_if.master mem,
  output logic [7:0]            music_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] TICK_MAX = CW'(CLK_DIV - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_LATENCY);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, start_q, end_q;
  logic              loop_q;
  logic [CW-1:0]     tick_cnt;
  logic [WW-1:0]     wait_cnt;
  logic [7:0]        sample_buf;
  logic              tick, at_end;
  logic [4:0]        vol_eff;
  logic [8:0]        centered;
  logic [14:0]       prod;
  logic [7:0]        scaled;

  assign tick    = (tick_cnt == TICK_MAX);
  assign at_end  = (addr == end_q);
  assign vol_eff = (volume > 5'd16) ? 5'd16 : volume;

  // Two's-complement product of the centred sample and gain; bits [11:4] are the >>>4 result.
  assign centered = {1'b0, sample_buf} - 9'd128;
  assign prod     = {{6{centered[8]}}, centered} * {10'd0, vol_eff};
  assign scaled   = prod[11:4] + 8'd128;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH:   state_nxt = WAIT;
        WAIT:    if (wait_cnt == WAIT_MAX) state_nxt = HOLD;
        HOLD:    if (tick) state_nxt = (at_end && !loop_q) ? IDLE : FETCH;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    mem.mem_rd_en = (state == FETCH);
    mem.mem_addr  = addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      start_q    <= '0;
      end_q      <= '0;
      loop_q     <= 1'b0;
      tick_cnt   <= '0;
      wait_cnt   <= '0;
      sample_buf <= 8'd0;
      music_data <= 8'd128;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        tick_cnt   <= '0;
        music_data <= 8'd128;
      end else if (start) begin
        start_q  <= start_addr;
        end_q    <= end_addr;
        loop_q   <= loop_en;
        addr     <= start_addr;
        tick_cnt <= '0;
      end else begin
        if (state == IDLE || tick) tick_cnt <= '0;
        else                       tick_cnt <= tick_cnt + 1'b1;
        case (state)
          FETCH: wait_cnt <= WW'(1);
          WAIT: begin
            if (wait_cnt == WAIT_MAX) sample_buf <= mem.mem_data;
            else                      wait_cnt   <= wait_cnt + 1'b1;
          end
          HOLD: begin
            if (tick) begin
              music_data <= scaled;
              if (!at_end)     addr <= addr + 1'b1;
              else if (loop_q) addr <= start_q;
              else             done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_player.sv
// Bench for audio_sample_player: sample-stream model driven by address/volume sequences and tick timing.
module tb_audio_sample_player;
  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop_en;
  logic [15:0] start_addr, end_addr;
  logic [4:0]  volume;
  logic [7:0]  music_data;
  logic        busy, done;

  audio_sample_player_if #(.ADDR_W(16)) bus ();

  audio_sample_player #(.CLK_DIV(DIV), .ADDR_W(16), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .volume(volume),
    .mem(bus.master), .music_data(music_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory: data for a read strobed in cycle n is valid only in cycle n+2; junk otherwise.
  logic [7:0]  mem [0:65535];
  logic [15:0] pa0, pa1;
  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic [7:0]  junk = 8'h00;
  always @(posedge clk) begin
    pv0  <= bus.mem_rd_en;
    pa0  <= bus.mem_addr;
    pv1  <= pv0;
    pa1  <= pa0;
    junk <= 8'($urandom);
  end
  assign bus.mem_data = pv1 ? mem[pa1] : junk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] cur_music;

  function automatic logic [7:0] scale_ref(input logic [7:0] b, input logic [4:0] v);
    int ve, p;
    ve = (v > 5'd16) ? 16 : int'(v);
    p  = (int'(b) - 128) * ve;
    return 8'((p >>> 4) + 128);
  endfunction

  // Start a playback and follow it cycle by cycle; max_cycles > 0 abandons it early (still busy).
  task automatic play(input logic [15:0] sa, input logic [15:0] ea, input bit lp,
                      input int nticks_in, input bit rnd_vol, input logic [4:0] vol_fixed,
                      input int max_cycles);
    logic [15:0] seq[$];
    logic [4:0]  vols[$];
    logic [15:0] a;
    int len, nticks, total;
    len    = int'(16'(ea - sa)) + 1;
    nticks = lp ? nticks_in : len;
    a = sa;
    for (int k = 0; k <= nticks; k++) begin
      seq.push_back(a);
      vols.push_back(rnd_vol ? 5'($urandom_range(0, 31)) : vol_fixed);
      a = (a == ea) ? sa : 16'(a + 16'd1);
    end
    total = DIV * nticks + 3;
    if (max_cycles > 0 && max_cycles < total) total = max_cycles;
    start_addr = sa; end_addr = ea; loop_en = lp; volume = vols[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_addr = 16'($urandom); end_addr = 16'($urandom); loop_en = ~lp;
    for (int c = 0; c <= total; c++) begin
      int k;
      bit rd_exp, done_exp, busy_exp;
      k        = c / DIV;
      rd_exp   = (c % DIV == 0) && (lp || c < DIV * nticks);
      done_exp = !lp && (c == DIV * nticks);
      busy_exp = lp || (c < DIV * nticks);
      if (c % DIV == 0 && c > 0) cur_music = scale_ref(mem[seq[k-1]], vols[k-1]);
      checks++;
      if (music_data !== cur_music) begin
        failures++;
        $display("FAIL music c=%0d sa=%h got=%0d exp=%0d", c, sa, music_data, cur_music);
      end
      checks++;
      if (bus.mem_rd_en !== rd_exp) begin
        failures++;
        $display("FAIL rd_en c=%0d sa=%h got=%b exp=%b", c, sa, bus.mem_rd_en, rd_exp);
      end
      if (rd_exp) begin
        checks++;
        if (bus.mem_addr !== seq[k]) begin
          failures++;
          $display("FAIL mem_addr c=%0d got=%h exp=%h", c, bus.mem_addr, seq[k]);
        end
      end
      checks++;
      if (done !== done_exp) begin
        failures++;
        $display("FAIL done c=%0d sa=%h got=%b exp=%b", c, sa, done, done_exp);
      end
      checks++;
      if (busy !== busy_exp) begin
        failures++;
        $display("FAIL busy c=%0d sa=%h got=%b exp=%b", c, sa, busy, busy_exp);
      end
      if (c % DIV == 3 && k < vols.size()) volume = vols[k];
      @(posedge clk); #1;
    end
  endtask

  task automatic load_basic();
    mem[0] = 8'd200; mem[1] = 8'd56; mem[2] = 8'd128;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; stop = 1'b1; loop_en = 1'b0;
    start_addr = 16'h1234; end_addr = 16'h1240; volume = 5'd16;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (music_data !== 8'd128 || busy !== 1'b0 || done !== 1'b0 ||
        bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 16'd0) begin
      failures++;
      $display("FAIL reset_state music=%0d busy=%b done=%b rd=%b addr=%h exp 128/0/0/0/0",
               music_data, busy, done, bus.mem_rd_en, bus.mem_addr);
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b rd=%b exp 0/0", busy, bus.mem_rd_en);
    end
    cur_music = 8'd128;
  endtask

  task automatic test_basic();
    load_basic();
    play(16'd0, 16'd2, 1'b0, 0, 1'b0, 5'd16, 0);
  endtask

  task automatic test_volume();
    logic [4:0] vl [3];
    vl[0] = 5'd8; vl[1] = 5'd0; vl[2] = 5'd31;
    load_basic();
    for (int i = 0; i < 3; i++) play(16'd0, 16'd2, 1'b0, 0, 1'b0, vl[i], 0);
  endtask

  task automatic test_loop();
    load_basic();
    play(16'd0, 16'd2, 1'b1, 7, 1'b0, 5'd16, 0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    cur_music = 8'd128;
    checks++;
    if (busy !== 1'b0 || music_data !== 8'd128 || done !== 1'b0) begin
      failures++;
      $display("FAIL loop_stop busy=%b music=%0d done=%b exp 0/128/0", busy, music_data, done);
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'($urandom); mem[16'h0000] = 8'($urandom);
    play(16'hFFFF, 16'h0000, 1'b0, 0, 1'b1, 5'd0, 0);
  endtask

  task automatic test_stop();
    load_basic();
    for (int m = 0; m < 2; m++) begin
      play(16'd0, 16'd2, 1'b0, 0, 1'b0, 5'd16, (m == 0) ? 1 : 9);
      stop = 1'b1;
      start = (m == 1);
      @(posedge clk); #1;
      stop = 1'b0; start = 1'b0;
      cur_music = 8'd128;
      checks++;
      if (busy !== 1'b0 || music_data !== 8'd128 || done !== 1'b0) begin
        failures++;
        $display("FAIL stop_case%0d busy=%b music=%0d done=%b exp 0/128/0",
                 m, busy, music_data, done);
      end
      for (int c = 0; c < 3 * DIV; c++) begin
        checks++;
        if (bus.mem_rd_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || music_data !== 8'd128) begin
          failures++;
          $display("FAIL stop_quiet%0d c=%0d rd=%b done=%b busy=%b music=%0d",
                   m, c, bus.mem_rd_en, done, busy, music_data);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) mem[100 + i] = 8'($urandom);
    mem[200] = 8'($urandom); mem[201] = 8'($urandom);
    play(16'd100, 16'd110, 1'b0, 0, 1'b1, 5'd0, 13);
    play(16'd200, 16'd201, 1'b0, 0, 1'b1, 5'd0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [15:0] sa, ea;
      bit lp;
      sa = 16'($urandom);
      ea = 16'(sa + 16'($urandom_range(0, 3)));
      lp = ($urandom_range(0, 2) == 0);
      for (int j = 0; j < 4; j++) mem[16'(sa + 16'(j))] = 8'($urandom);
      play(sa, ea, lp, 6, 1'b1, 5'd0, 0);
      if (lp) begin
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        cur_music = 8'd128;
        checks++;
        if (busy !== 1'b0 || music_data !== 8'd128) begin
          failures++;
          $display("FAIL rand_stop it=%0d busy=%b music=%0d exp 0/128", it, busy, music_data);
        end
      end
    end
  endtask

  task automatic test_reset_in_hold();
    load_basic();
    play(16'd0, 16'd2, 1'b0, 0, 1'b0, 5'd16, 11);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cur_music = 8'd128;
    checks++;
    if (music_data !== 8'd128 || busy !== 1'b0 || done !== 1'b0 ||
        bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 16'd0) begin
      failures++;
      $display("FAIL reset_hold music=%0d busy=%b done=%b rd=%b addr=%h exp 128/0/0/0/0",
               music_data, busy, done, bus.mem_rd_en, bus.mem_addr);
    end
    play(16'd0, 16'd2, 1'b0, 0, 1'b0, 5'd16, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_volume();
    test_loop();
    test_wrap();
    test_stop();
    test_back_to_back();
    test_random();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
